// File: rtl/debug_halt_ctrl_if.sv
// rtl/debug_halt_ctrl_if.sv - debugger command port and core run-control signal bundle
interface debug_halt_ctrl_if #(
  parameter int NUM_BP = 2
) ();
  localparam int IW = (NUM_BP > 1) ? $clog2(NUM_BP) : 1;

  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [IW-1:0] cmd_idx;
  logic [31:0]   cmd_data;
  logic [31:0]   pc;
  logic          stall;
  logic          halt_active;
  logic          reset_stages;
  logic          halted;
  logic [1:0]    halt_cause;
  logic [31:0]   dpc;
  logic          cmd_err;

  modport master (
    output cmd_valid, cmd_op, cmd_idx, cmd_data, pc, stall,
    input  cmd_ready, halt_active, reset_stages, halted, halt_cause, dpc, cmd_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_idx, cmd_data, pc, stall,
    output cmd_ready, halt_active, reset_stages, halted, halt_cause, dpc, cmd_err
  );
endinterface

// File: rtl/debug_halt_ctrl.sv
// rtl/debug_halt_ctrl.sv - debug run control: halt/resume/step/core-reset FSM with PC breakpoints
// Optional feature macro: DBG_BREAKPOINT_EN (hardware PC breakpoints and skip-on-resume).
module debug_halt_ctrl #(
  parameter int NUM_BP     = 2,
  parameter int RST_CYCLES = 2,
  parameter bit RESET_HALT = 1'b0
) (
  input logic               clk,
  input logic               reset,
  debug_halt_ctrl_if.slave  bus
);
  localparam logic [2:0]  OP_HALT       = 3'd1;
  localparam logic [2:0]  OP_RESUME     = 3'd2;
  localparam logic [2:0]  OP_STEP       = 3'd3;
  localparam logic [2:0]  OP_RESET_CORE = 3'd4;
  localparam logic [2:0]  OP_SET_BP     = 3'd5;
  localparam logic [2:0]  OP_CLR_BP     = 3'd6;
  localparam logic [2:0]  OP_RSVD       = 3'd7;

  localparam logic [1:0]  CAUSE_RESET = 2'd0;
  localparam logic [1:0]  CAUSE_HALT  = 2'd1;
  localparam logic [1:0]  CAUSE_BP    = 2'd2;
  localparam logic [1:0]  CAUSE_STEP  = 2'd3;

  localparam logic [31:0] RESET_PC = 32'h0000_0008;
  localparam int          CW       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CW-1:0] RST_LOAD = CW'(RST_CYCLES - 1);

  typedef enum logic [1:0] {S_RUN, S_HALTED, S_STEP, S_RSTP} state_t;
  localparam state_t S_RESET = RESET_HALT ? S_HALTED : S_RUN;

  state_t        r_state;
  logic          r_halted;
  logic          r_reset_stages;
  logic          r_cmd_err;
  logic          r_rst_to_halt;
  logic [1:0]    r_halt_cause;
  logic [31:0]   r_dpc;
  logic [CW-1:0] r_rst_cnt;

  logic w_cmd_ready;
  logic w_accept;
  logic w_illegal;
  logic w_enter_rstp;
  logic w_bp_hit;
  logic w_bp_present;

  assign w_cmd_ready  = (r_state == S_RUN) || (r_state == S_HALTED);
  assign w_accept     = bus.cmd_valid && w_cmd_ready;
  assign w_enter_rstp = w_accept && (bus.cmd_op == OP_RESET_CORE);

  assign w_illegal = (bus.cmd_op == OP_RSVD)
                  || ((r_state == S_RUN) && ((bus.cmd_op == OP_RESUME) || (bus.cmd_op == OP_STEP)))
                  || (!w_bp_present && ((bus.cmd_op == OP_SET_BP) || (bus.cmd_op == OP_CLR_BP)));

`ifdef DBG_BREAKPOINT_EN
  logic [31:0]       r_bp_addr [NUM_BP];
  logic [NUM_BP-1:0] r_bp_en;
  logic [NUM_BP-1:0] w_bp_match;
  logic              r_skip_bp;

  assign w_bp_present = 1'b1;

  always_comb begin
    w_bp_match = '0;
    for (int i = 0; i < NUM_BP; i++) begin
      w_bp_match[i] = r_bp_en[i] && (r_bp_addr[i] == bus.pc);
    end
  end

  assign w_bp_hit = (r_state == S_RUN) && !r_skip_bp && (|w_bp_match);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bp_en <= '0;
      for (int i = 0; i < NUM_BP; i++) begin
        r_bp_addr[i] <= '0;
      end
    end else if (w_accept) begin
      for (int i = 0; i < NUM_BP; i++) begin
        if (int'(bus.cmd_idx) == i) begin
          if (bus.cmd_op == OP_SET_BP) begin
            r_bp_addr[i] <= bus.cmd_data;
            r_bp_en[i]   <= 1'b1;
          end else if (bus.cmd_op == OP_CLR_BP) begin
            r_bp_en[i]   <= 1'b0;
          end
        end
      end
    end
  end

  // Resuming from a breakpoint must let the PC move off that address before re-arming.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_skip_bp <= 1'b0;
    end else if ((r_state == S_HALTED) && w_accept && (bus.cmd_op == OP_RESUME)) begin
      r_skip_bp <= 1'b1;
    end else if ((r_state == S_RUN) && !bus.stall) begin
      r_skip_bp <= 1'b0;
    end
  end
`else
  logic w_unused;

  assign w_bp_present = 1'b0;
  assign w_bp_hit     = 1'b0;
  assign w_unused     = &{1'b0, bus.cmd_idx, bus.cmd_data[31:1]};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= S_RESET;
      r_halted       <= RESET_HALT;
      r_reset_stages <= 1'b0;
      r_halt_cause   <= CAUSE_RESET;
      r_dpc          <= RESET_PC;
      r_cmd_err      <= 1'b0;
      r_rst_cnt      <= '0;
      r_rst_to_halt  <= 1'b0;
    end else begin
      r_cmd_err <= w_accept && w_illegal;
      if (r_halted) begin
        r_dpc <= bus.pc;
      end
      // A core reset outranks a coincident breakpoint hit; the breakpoint would be flushed anyway.
      if (w_enter_rstp) begin
        r_state        <= S_RSTP;
        r_halted       <= 1'b0;
        r_reset_stages <= 1'b1;
        r_rst_cnt      <= RST_LOAD;
        r_rst_to_halt  <= bus.cmd_data[0];
      end else begin
        unique case (r_state)
          S_RUN: begin
            if (w_bp_hit || (w_accept && (bus.cmd_op == OP_HALT))) begin
              r_state      <= S_HALTED;
              r_halted     <= 1'b1;
              r_halt_cause <= w_bp_hit ? CAUSE_BP : CAUSE_HALT;
            end
          end
          S_HALTED: begin
            if (w_accept && (bus.cmd_op == OP_RESUME)) begin
              r_state  <= S_RUN;
              r_halted <= 1'b0;
            end else if (w_accept && (bus.cmd_op == OP_STEP)) begin
              r_state  <= S_STEP;
              r_halted <= 1'b0;
            end
          end
          S_STEP: begin
            if (!bus.stall) begin
              r_state      <= S_HALTED;
              r_halted     <= 1'b1;
              r_halt_cause <= CAUSE_STEP;
            end
          end
          S_RSTP: begin
            if (r_rst_cnt == '0) begin
              r_reset_stages <= 1'b0;
              r_state        <= r_rst_to_halt ? S_HALTED : S_RUN;
              r_halted       <= r_rst_to_halt;
              if (r_rst_to_halt) begin
                r_halt_cause <= CAUSE_RESET;
              end
            end else begin
              r_rst_cnt <= r_rst_cnt - CW'(1);
            end
          end
          default: r_state <= S_RESET;
        endcase
      end
    end
  end

  // halt_active follows bp_hit combinationally so the PC never steps past a breakpoint.
  assign bus.cmd_ready    = w_cmd_ready;
  assign bus.halt_active  = (r_state == S_HALTED) || (r_state == S_RSTP) || w_bp_hit;
  assign bus.reset_stages = r_reset_stages;
  assign bus.halted       = r_halted;
  assign bus.halt_cause   = r_halt_cause;
  assign bus.dpc          = r_dpc;
  assign bus.cmd_err      = r_cmd_err;
endmodule

// File: tb/tb_debug_halt_ctrl.sv
// tb/tb_debug_halt_ctrl.sv - scoreboard bench for debug_halt_ctrl against a cycle-level reference model
module tb_debug_halt_ctrl;
  localparam int NUM_BP     = 2;
  localparam int RST_CYCLES = 2;
  localparam bit RESET_HALT = 1'b0;
  localparam int IW         = $clog2(NUM_BP);
`ifdef DBG_BREAKPOINT_EN
  localparam bit HAS_BP = 1'b1;
`else
  localparam bit HAS_BP = 1'b0;
`endif

  localparam logic [2:0] NOP = 3'd0, HALT = 3'd1, RESUME = 3'd2, STEP = 3'd3;
  localparam logic [2:0] RCORE = 3'd4, SETBP = 3'd5, CLRBP = 3'd6, RSVD = 3'd7;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  debug_halt_ctrl_if #(.NUM_BP(NUM_BP)) bus ();

  debug_halt_ctrl #(.NUM_BP(NUM_BP), .RST_CYCLES(RST_CYCLES), .RESET_HALT(RESET_HALT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic        rdy;
    logic        hact;
    logic        rstg;
    logic        hlt;
    logic [1:0]  cause;
    logic [31:0] dpc;
    logic        err;
  } exp_t;

  typedef enum {RUNNING, STOPPED, STEPPING, RESETTING} mode_e;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  mode_e       m_mode;
  logic [31:0] m_bp_addr [NUM_BP];
  bit          m_bp_on [NUM_BP];
  bit          m_skip;
  int          m_rst_left;
  bit          m_rst_halt;
  logic [1:0]  m_cause;
  logic [31:0] m_dpc;
  bit          m_err;
  logic [31:0] env_pc = 32'h8;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: evaluates one clock cycle from the debugger-visible rules.
  task automatic model_cycle();
    exp_t e;
    bit hit, acc, ill;
    if (!reset) begin
      m_mode = RESET_HALT ? STOPPED : RUNNING;
      for (int i = 0; i < NUM_BP; i++) begin
        m_bp_addr[i] = '0;
        m_bp_on[i]   = 1'b0;
      end
      m_skip = 0; m_cause = 2'd0; m_dpc = 32'h8; m_err = 0; m_rst_left = 0; m_rst_halt = 0;
    end
    hit = 0;
    if (m_mode == RUNNING && !m_skip)
      for (int i = 0; i < NUM_BP; i++)
        if (m_bp_on[i] && m_bp_addr[i] == bus.pc) hit = 1;
    e.rdy   = (m_mode == RUNNING) || (m_mode == STOPPED);
    e.hact  = (m_mode == STOPPED) || (m_mode == RESETTING) || hit;
    e.rstg  = (m_mode == RESETTING);
    e.hlt   = (m_mode == STOPPED);
    e.cause = m_cause;
    e.dpc   = m_dpc;
    e.err   = m_err;
    exp_q.push_back(e);

    if (!reset) begin
      env_pc = 32'h8;
      return;
    end
    if (e.rstg) env_pc = 32'h8;
    else if (!e.hact && !bus.stall) env_pc = env_pc + 32'd4;

    acc = bus.cmd_valid && e.rdy;
    ill = (bus.cmd_op == RSVD) || (m_mode == RUNNING && (bus.cmd_op == RESUME || bus.cmd_op == STEP))
       || (!HAS_BP && (bus.cmd_op == SETBP || bus.cmd_op == CLRBP));
    m_err = acc && ill;
    if (e.hlt) m_dpc = bus.pc;
    if (acc && HAS_BP && bus.cmd_op == SETBP) begin
      m_bp_addr[int'(bus.cmd_idx)] = bus.cmd_data;
      m_bp_on[int'(bus.cmd_idx)]   = 1'b1;
    end
    if (acc && HAS_BP && bus.cmd_op == CLRBP) m_bp_on[int'(bus.cmd_idx)] = 1'b0;

    if (acc && bus.cmd_op == RCORE) begin
      m_mode = RESETTING; m_rst_left = RST_CYCLES; m_rst_halt = bus.cmd_data[0];
      if (e.rdy && !e.hlt && !bus.stall) m_skip = 0;
    end else begin
      case (m_mode)
        RUNNING: begin
          if (!bus.stall) m_skip = 0;
          if (hit) begin m_mode = STOPPED; m_cause = 2'd2; end
          else if (acc && bus.cmd_op == HALT) begin m_mode = STOPPED; m_cause = 2'd1; end
        end
        STOPPED: begin
          if (acc && bus.cmd_op == RESUME) begin m_mode = RUNNING; m_skip = HAS_BP; end
          else if (acc && bus.cmd_op == STEP) m_mode = STEPPING;
        end
        STEPPING: if (!bus.stall) begin m_mode = STOPPED; m_cause = 2'd3; end
        RESETTING: begin
          m_rst_left--;
          if (m_rst_left == 0) begin
            m_mode = m_rst_halt ? STOPPED : RUNNING;
            if (m_rst_halt) m_cause = 2'd0;
          end
        end
        default: m_mode = RUNNING;
      endcase
    end
  endtask

  task automatic cycle(input bit v, input logic [2:0] op, input int idx, input logic [31:0] data,
                       input bit st, input bit rstn);
    @(posedge clk);
    #1;
    reset         = rstn;
    bus.cmd_valid = v;
    bus.cmd_op    = op;
    bus.cmd_idx   = idx[IW-1:0];
    bus.cmd_data  = data;
    bus.stall     = st;
    bus.pc        = env_pc;
    @(negedge clk);
    model_cycle();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, NOP, 0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic run_to_pc(input logic [31:0] target);
    for (int k = 0; k < 64 && env_pc != target; k++) idle(1);
    chk("reach_pc_timeout", env_pc, target);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("cmd_ready",    {31'd0, bus.cmd_ready},    {31'd0, e.rdy});
        chk("halt_active",  {31'd0, bus.halt_active},  {31'd0, e.hact});
        chk("reset_stages", {31'd0, bus.reset_stages}, {31'd0, e.rstg});
        chk("halted",       {31'd0, bus.halted},       {31'd0, e.hlt});
        chk("halt_cause",   {30'd0, bus.halt_cause},   {30'd0, e.cause});
        chk("dpc",          bus.dpc,                   e.dpc);
        chk("cmd_err",      {31'd0, bus.cmd_err},      {31'd0, e.err});
      end
    end
  end

  initial begin : driver
    logic [31:0] pc_mark;
    bus.cmd_valid = 0; bus.cmd_op = NOP; bus.cmd_idx = '0; bus.cmd_data = '0;
    bus.stall = 0; bus.pc = 32'h8;

    cycle(0, NOP, 0, 0, 0, 0);
    cycle(0, NOP, 0, 0, 0, 0);
    #2 chk("rst_halted", {31'd0, bus.halted}, {31'd0, RESET_HALT});
    chk("rst_dpc", bus.dpc, 32'h8);

    run_to_pc(32'h20);
    cycle(1, HALT, 0, 0, 0, 1);
    idle(1);
    #2 chk("halt_halted", {31'd0, bus.halted}, 32'd1);
    chk("halt_cause_req", {30'd0, bus.halt_cause}, 32'd1);
    pc_mark = env_pc;
    idle(10);
    #2 chk("halt_dpc_held", bus.dpc, pc_mark);

`ifdef DBG_BREAKPOINT_EN
    cycle(1, SETBP, 0, pc_mark + 32'hC, 0, 1);
    cycle(1, RESUME, 0, 0, 0, 1);
    run_to_pc(pc_mark + 32'hC);
    idle(1);
    #2 chk("bp_halt_active", {31'd0, bus.halt_active}, 32'd1);
    idle(2);
    #2 chk("bp_cause", {30'd0, bus.halt_cause}, 32'd2);
    chk("bp_dpc", bus.dpc, pc_mark + 32'hC);
    cycle(1, RESUME, 0, 0, 0, 1);
    idle(2);
    #2 chk("bp_skip_running", {31'd0, bus.halted}, 32'd0);
`else
    cycle(1, SETBP, 0, pc_mark + 32'hC, 0, 1);
    idle(1);
    #2 chk("setbp_err", {31'd0, bus.cmd_err}, 32'd1);
`endif

    cycle(1, HALT, 0, 0, 0, 1);
    idle(1);
    pc_mark = env_pc;
    cycle(1, STEP, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(0, NOP, 0, 0, 1, 1);
      #2 chk("step_ready_low", {31'd0, bus.cmd_ready}, 32'd0);
      chk("step_hact_low", {31'd0, bus.halt_active}, 32'd0);
    end
    cycle(0, NOP, 0, 0, 0, 1);
    idle(2);
    #2 chk("step_cause", {30'd0, bus.halt_cause}, 32'd3);
    chk("step_dpc", bus.dpc, pc_mark + 32'd4);

    cycle(1, RESUME, 0, 0, 0, 1);
    idle(2);
    cycle(1, RCORE, 0, 32'h1, 0, 1);
    idle(1);
    #2 chk("rcore_stages_1", {31'd0, bus.reset_stages}, 32'd1);
    idle(1);
    #2 chk("rcore_stages_2", {31'd0, bus.reset_stages}, 32'd1);
    idle(1);
    #2 chk("rcore_stages_off", {31'd0, bus.reset_stages}, 32'd0);
    chk("rcore_cause", {30'd0, bus.halt_cause}, 32'd0);
    idle(1);
    #2 chk("rcore_dpc", bus.dpc, 32'h8);

    cycle(1, RESUME, 0, 0, 0, 1);
    idle(1);
    cycle(1, RESUME, 0, 0, 0, 1);
    idle(1);
    #2 chk("resume_run_err", {31'd0, bus.cmd_err}, 32'd1);
    cycle(1, RSVD, 0, 0, 0, 1);
    idle(1);
    #2 chk("rsvd_err", {31'd0, bus.cmd_err}, 32'd1);

    cycle(1, HALT, 0, 0, 0, 1);
    cycle(1, STEP, 0, 0, 0, 1);
    cycle(0, NOP, 0, 0, 1, 1);
    cycle(0, NOP, 0, 0, 1, 0);
    #2 chk("areset_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("areset_dpc", bus.dpc, 32'h8);
    idle(2);

    for (int n = 0; n < 3000; n++) begin
      logic [2:0]  op;
      logic [31:0] data;
      op   = 3'($urandom_range(0, 7));
      data = (op == SETBP) ? env_pc + 32'(4 * $urandom_range(0, 8)) : $urandom;
      cycle($urandom_range(0, 99) < 35, op, $urandom_range(0, NUM_BP - 1), data,
            $urandom_range(0, 3) == 0, $urandom_range(0, 299) != 0);
    end

    repeat (3) @(negedge clk);
    #3 chk("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
